// File: rtl/commit_trace_tx.sv
// commit_trace_tx: captures one retirement record per committed instruction,
// queues it in a small FIFO and serialises it as a framed stream of 32-bit
// words (HDR, PC, INSTR, [RFD], [MADDR, MDATA]) over valid/ready.
// Ports:
//   clk_i, rst_n                 clock, asynchronous active-low reset
//   commit_* / rf_* / mem_*      retirement record capture
//   trace_valid_o/data_o/last_o  registered trace stream, trace_ready_i back-pressure
//   full_o                       FIFO holds DEPTH records (combinational)
//   overflow_o, drop_cnt_o       sticky drop flag and saturating drop count
module commit_trace_tx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             commit_valid_i,
  input  logic [31:0]      commit_pc_i,
  input  logic [31:0]      commit_instr_i,
  input  logic             rf_we_i,
  input  logic [4:0]       rf_waddr_i,
  input  logic [31:0]      rf_wdata_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic             trace_valid_o,
  output logic [31:0]      trace_data_o,
  output logic             trace_last_o,
  input  logic             trace_ready_i,
  output logic             full_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_PC    = 3'd2;
  localparam logic [2:0] S_INSTR = 3'd3;
  localparam logic [2:0] S_RFD   = 3'd4;
  localparam logic [2:0] S_MADDR = 3'd5;
  localparam logic [2:0] S_MDATA = 3'd6;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             rf;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic             mw;
    logic [31:0]      maddr;
    logic [31:0]      mdata;
    logic [CNT_W-1:0] seq;
  } rec_t;

  // Word presented in state s for record r.
  function automatic logic [31:0] word_of(input logic [2:0] s, input rec_t r);
    logic [3:0] n;
    n = 4'd3 + 4'(r.rf) + (r.mw ? 4'd2 : 4'd0);
    case (s)
      S_HDR:   word_of = {4'hA, n, r.rf, r.mw, 1'b0, r.waddr, 16'(r.seq)};
      S_PC:    word_of = r.pc;
      S_INSTR: word_of = r.instr;
      S_RFD:   word_of = r.wdata;
      S_MADDR: word_of = r.maddr;
      S_MDATA: word_of = r.mdata;
      default: word_of = 32'd0;
    endcase
  endfunction

  function automatic logic is_last(input logic [2:0] s, input rec_t r);
    is_last = (s == S_INSTR && !r.rf && !r.mw) || (s == S_RFD && !r.mw) ||
              (s == S_MDATA);
  endfunction

  // Successor of a non-final word.
  function automatic logic [2:0] succ(input logic [2:0] s, input rec_t r);
    case (s)
      S_HDR:   succ = S_PC;
      S_PC:    succ = S_INSTR;
      S_INSTR: succ = r.rf ? S_RFD : S_MADDR;
      S_RFD:   succ = S_MADDR;
      S_MADDR: succ = S_MDATA;
      default: succ = S_IDLE;
    endcase
  endfunction

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] seq;
  logic [2:0]       state, state_d;
  logic             valid_d, last_d;
  logic [31:0]      data_d;

  rec_t             in_rec, head, nrec;
  logic             fire, pop, push, drop, have_next;
  logic [CW-1:0]    remaining;
  logic [PTR_W-1:0] nidx;
  logic [2:0]       adv;

  assign full_o = (count == CW'(DEPTH));
  assign fire   = trace_valid_o && trace_ready_i;
  assign pop    = fire && trace_last_o;
  assign push   = commit_valid_i && (!full_o || pop);
  assign drop   = commit_valid_i && full_o && !pop;

  // Record capture; a write to r0 is never reported.
  always_comb begin
    in_rec       = '0;
    in_rec.pc    = commit_pc_i;
    in_rec.instr = commit_instr_i;
    in_rec.rf    = rf_we_i && (rf_waddr_i != 5'd0);
    in_rec.waddr = in_rec.rf ? rf_waddr_i : 5'd0;
    in_rec.wdata = rf_wdata_i;
    in_rec.mw    = mem_we_i;
    in_rec.maddr = mem_addr_i;
    in_rec.mdata = mem_wdata_i;
    in_rec.seq   = seq;
  end

  // Next record to start: the FIFO entry after any pop, or the incoming commit
  // when the FIFO drains this cycle (gives the one-cycle push-to-HDR latency).
  assign head      = mem[rd_ptr];
  assign remaining = count - CW'(pop);
  assign nidx      = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign nrec      = (remaining != '0) ? mem[nidx] : in_rec;
  assign have_next = (remaining != '0) || push;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    valid_d = trace_valid_o;
    data_d  = trace_data_o;
    last_d  = trace_last_o;
    adv     = succ(state, head);
    if (state == S_IDLE || pop) begin
      if (have_next) begin
        state_d = S_HDR;
        valid_d = 1'b1;
        data_d  = word_of(S_HDR, nrec);
        last_d  = 1'b0;
      end else begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        data_d  = 32'd0;
        last_d  = 1'b0;
      end
    end else if (fire) begin
      state_d = adv;
      data_d  = word_of(adv, head);
      last_d  = is_last(adv, head);
    end
  end

  // FSM, output and FIFO bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      trace_valid_o <= 1'b0;
      trace_data_o  <= 32'd0;
      trace_last_o  <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      seq           <= '0;
      overflow_o    <= 1'b0;
      drop_cnt_o    <= '0;
    end else begin
      state         <= state_d;
      trace_valid_o <= valid_d;
      trace_data_o  <= data_d;
      trace_last_o  <= last_d;
      count         <= count + CW'(push) - CW'(pop);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        seq    <= seq + CNT_W'(1);
      end
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      end
    end
  end

  // Record storage.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_rec;
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             commit_valid_i = 1'b0;
  logic [31:0]      commit_pc_i = '0, commit_instr_i = '0;
  logic             rf_we_i = 1'b0;
  logic [4:0]       rf_waddr_i = '0;
  logic [31:0]      rf_wdata_i = '0;
  logic             mem_we_i = 1'b0;
  logic [31:0]      mem_addr_i = '0, mem_wdata_i = '0;
  logic             trace_valid_o, trace_last_o, full_o, overflow_o;
  logic [31:0]      trace_data_o;
  logic             trace_ready_i = 1'b0;
  logic [CNT_W-1:0] drop_cnt_o;

  commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .rf_wdata_i(rf_wdata_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .trace_valid_o(trace_valid_o),
    .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
    .trace_ready_i(trace_ready_i), .full_o(full_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] exp_q[$];          // {last, data}
  int          m_cnt = 0;
  logic [15:0] m_seq = '0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;

  // Scoreboard: model pushes on accepted commits, compares every transfer.
  always @(negedge clk_i) begin
    logic        pop_now, eff;
    logic [3:0]  n;
    logic [32:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_seq = '0;
      prev_stall = 1'b0;
    end else begin
      pop_now = trace_valid_o && trace_ready_i && trace_last_o;
      if (prev_stall) begin
        vectors++;
        if ({trace_valid_o, trace_last_o, trace_data_o} !== prev_word) begin
          miscompares++;
          $display("FAIL stall_hold: got %h want %h", {trace_valid_o, trace_last_o, trace_data_o}, prev_word);
        end
      end
      if (trace_valid_o && trace_ready_i) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got %h want none", trace_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({trace_last_o, trace_data_o} !== e) begin
            miscompares++;
            $display("FAIL stream_word: got last=%b data=%h want last=%b data=%h",
                     trace_last_o, trace_data_o, e[32], e[31:0]);
          end
        end
      end
      if (commit_valid_i) begin
        if (m_cnt < int'(DEPTH) || pop_now) begin
          eff = rf_we_i && (rf_waddr_i != 5'd0);
          n = 4'd3 + 4'(eff) + (mem_we_i ? 4'd2 : 4'd0);
          exp_q.push_back({1'b0, 4'hA, n, eff, mem_we_i, 1'b0, (eff ? rf_waddr_i : 5'd0), m_seq});
          exp_q.push_back({1'b0, commit_pc_i});
          exp_q.push_back({!eff && !mem_we_i, commit_instr_i});
          if (eff) exp_q.push_back({!mem_we_i, rf_wdata_i});
          if (mem_we_i) begin
            exp_q.push_back({1'b0, mem_addr_i});
            exp_q.push_back({1'b1, mem_wdata_i});
          end
          m_seq++;
          m_cnt++;
        end
      end
      if (pop_now) m_cnt--;
      prev_stall = trace_valid_o && !trace_ready_i;
      prev_word  = {trace_valid_o, trace_last_o, trace_data_o};
    end
  end

  // Drive one commit for one cycle; returns at posedge+1.
  task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                        input logic rfwe, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mwe, input logic [31:0] ma, input logic [31:0] md);
    commit_valid_i = 1'b1; commit_pc_i = pc; commit_instr_i = instr;
    rf_we_i = rfwe; rf_waddr_i = wa; rf_wdata_i = wd;
    mem_we_i = mwe; mem_addr_i = ma; mem_wdata_i = md;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    trace_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !trace_valid_o) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d words pending want 0", exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 6;
    if (trace_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", trace_valid_o); end
    if (trace_data_o !== 32'd0) begin miscompares++; $display("FAIL rst_data: got %h want 0", trace_data_o); end
    if (trace_last_o !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %b want 0", trace_last_o); end
    if (full_o !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", full_o); end
    if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow_o); end
    if (drop_cnt_o !== '0) begin miscompares++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_single();
    trace_ready_i = 1'b1;
    commit_valid_i = 1'b1; commit_pc_i = 32'h0; commit_instr_i = 32'h20010005;
    rf_we_i = 1'b1; rf_waddr_i = 5'd1; rf_wdata_i = 32'd5;
    mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    @(negedge clk_i);
    vectors++;
    if (trace_valid_o !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %b want 0", trace_valid_o); end
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0;
    vectors++;
    if ({trace_valid_o, trace_data_o} !== {1'b1, 32'hA4810000}) begin
      miscompares++;
      $display("FAIL latency_hdr: got v=%b %h want v=1 a4810000", trace_valid_o, trace_data_o);
    end
    wait_drain();
  endtask

  task automatic test_store();
    commit(32'h4, 32'hAC070010, 1'b0, 5'd7, 32'h0, 1'b1, 32'h10, 32'h7);
    vectors++;
    if ({trace_valid_o, trace_data_o} !== {1'b1, 32'hA5400001}) begin
      miscompares++;
      $display("FAIL store_hdr: got v=%b %h want v=1 a5400001", trace_valid_o, trace_data_o);
    end
    wait_drain();
  endtask

  task automatic test_r0_write();
    commit(32'h8, 32'h20000009, 1'b1, 5'd0, 32'h9, 1'b0, 32'h0, 32'h0);
    vectors++;
    if ({trace_valid_o, trace_data_o} !== {1'b1, 32'hA3000002}) begin
      miscompares++;
      $display("FAIL r0_hdr: got v=%b %h want v=1 a3000002", trace_valid_o, trace_data_o);
    end
    wait_drain();
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready_i = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      commit(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), (i % 2) == 1, 5'(i + 2),
             32'hBEEF0000 + 32'(i), (i % 3) == 0, 32'h200 + 32'(i), 32'hC0DE0000 + 32'(i));
      if (i == int'(DEPTH) - 1) begin
        vectors++;
        if (full_o !== 1'b1) begin miscompares++; $display("FAIL full_after_fill: got %b want 1", full_o); end
      end
    end
    vectors += 2;
    if (overflow_o !== 1'b1) begin miscompares++; $display("FAIL overflow_flag: got %b want 1", overflow_o); end
    if (drop_cnt_o !== CNT_W'(2)) begin miscompares++; $display("FAIL drop_cnt: got %0d want 2", drop_cnt_o); end
    repeat (3) @(posedge clk_i);
    #1;
    wait_drain();
  endtask

  task automatic test_full_pop();
    logic found;
    do_reset();
    trace_ready_i = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++)
      commit(32'h300 + 32'(4 * i), 32'h00000013, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    trace_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #1;
      if (trace_valid_o && trace_last_o) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL full_pop_last: got no last word want last");
    end
    commit(32'h400, 32'h2002000B, 1'b1, 5'd2, 32'hB, 1'b0, 32'h0, 32'h0);
    vectors += 3;
    if (full_o !== 1'b1) begin miscompares++; $display("FAIL full_pop_full: got %b want 1", full_o); end
    if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL full_pop_overflow: got %b want 0", overflow_o); end
    if (drop_cnt_o !== '0) begin miscompares++; $display("FAIL full_pop_drops: got %0d want 0", drop_cnt_o); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic found;
    trace_ready_i = 1'b1;
    commit(32'h500, 32'h20030003, 1'b1, 5'd3, 32'h3, 1'b1, 32'h40, 32'h44);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (trace_valid_o && trace_data_o == 32'h20030003) begin
        found = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL mid_instr_seen: got no INSTR word want 20030003"); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({trace_valid_o, trace_last_o, trace_data_o} !== 34'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got v=%b l=%b %h want 0", trace_valid_o, trace_last_o, trace_data_o);
    end
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    commit(32'h600, 32'h00000013, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if ({trace_valid_o, trace_data_o} !== {1'b1, 32'hA3000000}) begin
      miscompares++;
      $display("FAIL post_reset_seq0: got v=%b %h want v=1 a3000000", trace_valid_o, trace_data_o);
    end
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_store();
    test_r0_write();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
